vram_arbiter: RTL and testbench

Responder side of the video-memory interface. Accepts pixel-fetch read requests from the VGA controller and read/write requests from the Core, and arbitrates them onto one single-port synchronous RAM. The RAM has 1-cycle read latency. Sits between VGAcontrollerTop/Core and the RAM array, in place of direct wiring to MemoryController.

---
 rtl/vram_pkg.sv | 36 +++
 rtl/vram_arb_pick.sv | 47 ++++
 rtl/vram_arbiter.sv | 145 ++++++++++++++
 tb/tb_vram_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// ---------------------------------------------------------------------------
// vram_pkg
// Shared definitions for the video-memory arbiter:
//   - default address/data widths
//   - arbiter FSM state encoding
//   - read-return requester tags
//   - saturation limit of the starvation counter and a 16-bit saturating
//     increment used by the optional statistics counters
// ---------------------------------------------------------------------------
package vram_pkg;

    localparam int ADDR_W_DEF = 24;
    localparam int DATA_W_DEF = 16;

    localparam logic [1:0] ST_IDLE          = 2'd0;
    localparam logic [1:0] ST_ISSUE_VGA     = 2'd1;
    localparam logic [1:0] ST_ISSUE_CORE_RD = 2'd2;
    localparam logic [1:0] ST_ISSUE_CORE_WR = 2'd3;

    typedef enum logic [1:0] {
        IDLE          = ST_IDLE,
        ISSUE_VGA     = ST_ISSUE_VGA,
        ISSUE_CORE_RD = ST_ISSUE_CORE_RD,
        ISSUE_CORE_WR = ST_ISSUE_CORE_WR
    } arb_state_t;

    localparam logic TAG_VGA  = 1'b0;
    localparam logic TAG_CORE = 1'b1;

    localparam logic [3:0] WAIT_SAT = 4'd15;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/vram_arb_pick.sv
// ---------------------------------------------------------------------------
// vram_arb_pick
// Priority selection between the VGA and core requesters plus the core
// starvation counter. VGA wins by default; the core wins when VGA is idle or
// after MAX_CORE_WAIT consecutive VGA grants while the core was waiting.
//
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   vga_req     - VGA request pending
//   core_req    - core request pending
//   grant_vga   - VGA is issued this cycle (combinational)
//   grant_core  - core is issued this cycle (combinational)
// ---------------------------------------------------------------------------
module vram_arb_pick
    import vram_pkg::*;
#(
    parameter int MAX_CORE_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic vga_req,
    input  logic core_req,
    output logic grant_vga,
    output logic grant_core
);

    localparam logic [3:0] MAX_WAIT = 4'(MAX_CORE_WAIT);

    logic [3:0] wait_cnt;
    logic       starved;

    assign starved    = (wait_cnt >= MAX_WAIT);
    assign grant_core = core_req && (!vga_req || starved);
    assign grant_vga  = vga_req && !grant_core;

    // Counts VGA grants that went ahead of a waiting core request.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= 4'd0;
        end else if (!core_req || grant_core) begin
            wait_cnt <= 4'd0;
        end else if (grant_vga && (wait_cnt != WAIT_SAT)) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
// Arbitrates VGA pixel-fetch reads and core reads/writes onto one
// single-port synchronous RAM (1-cycle read latency). One access per cycle;
// the ack pulse and the registered RAM drive appear in the same cycle.
// Read data is returned one cycle after issue, steered by a requester tag.
//
// Ports:
//   clk, reset                   - system clock, synchronous active-high reset
//   vga_req/vga_addr             - VGA read request (held until vga_ack)
//   vga_ack                      - VGA request issued to RAM
//   vga_rvalid/vga_rdata         - VGA read return (rdata holds otherwise)
//   core_req/core_we/core_addr/core_wdata - core request (held until core_ack)
//   core_ack                     - core request issued to RAM
//   core_rvalid/core_rdata       - core read return (reads only)
//   mem_addr/mem_we/mem_wdata    - registered RAM drive
//   mem_rdata                    - RAM read data, valid the cycle after issue
//   stat_core_stall, stat_forced - only with VRAM_ARB_STATS_EN defined
//
// Build option: define VRAM_ARB_STATS_EN to add the core stall and
// forced-grant statistics counters.
//
// state         | meaning
// --------------+-----------------------------------------------
// IDLE          | no access issued this cycle
// ISSUE_VGA     | VGA read on the RAM bus this cycle
// ISSUE_CORE_RD | core read on the RAM bus this cycle
// ISSUE_CORE_WR | core write on the RAM bus this cycle (mem_we=1)
// ---------------------------------------------------------------------------
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int MAX_CORE_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_ack,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_ack,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef VRAM_ARB_STATS_EN
    ,
    output logic [15:0]       stat_core_stall,
    output logic [15:0]       stat_forced
`endif
);

    arb_state_t        state;
    logic              grant_vga;
    logic              grant_core;
    logic              ret_valid;
    logic              ret_tag;
    logic [DATA_W-1:0] vga_rdata_q;
    logic [DATA_W-1:0] core_rdata_q;

    vram_arb_pick #(
        .MAX_CORE_WAIT (MAX_CORE_WAIT)
    ) u_pick (
        .clk        (clk),
        .reset      (reset),
        .vga_req    (vga_req),
        .core_req   (core_req),
        .grant_vga  (grant_vga),
        .grant_core (grant_core)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            vga_ack   <= 1'b0;
            core_ack  <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            ret_valid <= 1'b0;
            ret_tag   <= TAG_VGA;
        end else begin
            vga_ack  <= grant_vga;
            core_ack <= grant_core;
            mem_we   <= grant_core && core_we;

            if (grant_vga) begin
                state    <= ISSUE_VGA;
                mem_addr <= vga_addr;
            end else if (grant_core) begin
                state     <= core_we ? ISSUE_CORE_WR : ISSUE_CORE_RD;
                mem_addr  <= core_addr;
                mem_wdata <= core_wdata;
            end else begin
                state <= IDLE;
            end

            // The state register is the issue stage; this stage lines up with
            // the RAM's read output one cycle later.
            ret_valid <= (state == ISSUE_VGA) || (state == ISSUE_CORE_RD);
            ret_tag   <= (state == ISSUE_VGA) ? TAG_VGA : TAG_CORE;
        end
    end

    assign vga_rvalid  = ret_valid && (ret_tag == TAG_VGA);
    assign core_rvalid = ret_valid && (ret_tag == TAG_CORE);

    // RAM data is only valid during the return cycle, so it is passed
    // straight through then and captured for holding afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            vga_rdata_q  <= '0;
            core_rdata_q <= '0;
        end else begin
            if (vga_rvalid)  vga_rdata_q  <= mem_rdata;
            if (core_rvalid) core_rdata_q <= mem_rdata;
        end
    end

    assign vga_rdata  = vga_rvalid  ? mem_rdata : vga_rdata_q;
    assign core_rdata = core_rvalid ? mem_rdata : core_rdata_q;

`ifdef VRAM_ARB_STATS_EN
    // A core grant while VGA is still requesting can only be starvation-forced.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_core_stall <= 16'd0;
            stat_forced     <= 16'd0;
        end else begin
            if (core_req && !grant_core) stat_core_stall <= sat_inc16(stat_core_stall);
            if (grant_core && vga_req)   stat_forced     <= sat_inc16(stat_forced);
        end
    end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        vga_req;
    logic [23:0] vga_addr;
    logic        vga_ack;
    logic        vga_rvalid;
    logic [15:0] vga_rdata;
    logic        core_req;
    logic        core_we;
    logic [23:0] core_addr;
    logic [15:0] core_wdata;
    logic        core_ack;
    logic        core_rvalid;
    logic [15:0] core_rdata;
    logic [23:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
`ifdef VRAM_ARB_STATS_EN
    logic [15:0] stat_core_stall;
    logic [15:0] stat_forced;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] exp_vga[$];
    logic [15:0] exp_core[$];

    logic [15:0] ram [0:255];

    vram_arbiter #(
        .ADDR_W        (24),
        .DATA_W        (16),
        .MAX_CORE_WAIT (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .vga_req     (vga_req),
        .vga_addr    (vga_addr),
        .vga_ack     (vga_ack),
        .vga_rvalid  (vga_rvalid),
        .vga_rdata   (vga_rdata),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_ack    (core_ack),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
`ifdef VRAM_ARB_STATS_EN
        ,
        .stat_core_stall (stat_core_stall),
        .stat_forced     (stat_forced)
`endif
    );

    always #5 clk = ~clk;

    // Write-first synchronous RAM with 1-cycle read latency.
    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 16'h0100 + 16'(i);
        mem_rdata = 16'h0;
    end

    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr[7:0]] <= mem_wdata;
            mem_rdata          <= mem_wdata;
        end else begin
            mem_rdata <= ram[mem_addr[7:0]];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        int rv;
        reset = 1'b1;
        vga_req = 1'b0; vga_addr = '0;
        core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if ({vga_ack, core_ack, vga_rvalid, core_rvalid, mem_we} !== 5'b0)
            $display("FAIL reset_strobes got %b exp 00000", {vga_ack, core_ack, vga_rvalid, core_rvalid, mem_we});
        else n_pass++;
        n_checks++;
        if ({mem_addr, mem_wdata, vga_rdata, core_rdata} !== 72'h0)
            $display("FAIL reset_buses got %h exp 0", {mem_addr, mem_wdata, vga_rdata, core_rdata});
        else n_pass++;

        // VGA read issued, then reset while it is in flight
        vga_req = 1'b1; vga_addr = 24'h000010;
        tick();
        n_checks++;
        if (vga_ack !== 1'b1 || mem_addr !== 24'h000010)
            $display("FAIL rst_mid_ack got ack=%b addr=%h exp ack=1 addr=000010", vga_ack, mem_addr);
        else n_pass++;
        vga_req = 1'b0;
        reset = 1'b1;
        tick();
        rv = (vga_rvalid || core_rvalid) ? 1 : 0;
        reset = 1'b0;
        repeat (3) begin
            tick();
            if (vga_rvalid || core_rvalid) rv++;
        end
        n_checks++;
        if (rv != 0) $display("FAIL rst_mid_no_rvalid got %0d pulses exp 0", rv);
        else n_pass++;
        n_checks++;
        if ({vga_ack, core_ack, mem_we, mem_addr, vga_rdata, core_rdata} !== 59'h0)
            $display("FAIL rst_mid_outputs got %h exp 0", {vga_ack, core_ack, mem_we, mem_addr, vga_rdata, core_rdata});
        else n_pass++;
    endtask

    task automatic test_vga_stream;
        int nack = 0;
        int nrv = 0;
        int nxt = 0;
        logic prev_ack = 1'b0;
        logic [15:0] e;
        vga_req = 1'b1; vga_addr = 24'd0;
        exp_vga.push_back(16'h0100);
        for (int c = 0; c < 12; c++) begin
            tick();
            n_checks++;
            if (vga_rvalid !== prev_ack)
                $display("FAIL stream_rvalid_latency cycle %0d got %b exp %b", c, vga_rvalid, prev_ack);
            else n_pass++;
            if (vga_rvalid) begin
                nrv++;
                n_checks++;
                if (exp_vga.size() == 0) begin
                    $display("FAIL stream_unexpected_rvalid got data %h exp none", vga_rdata);
                end else begin
                    e = exp_vga.pop_front();
                    if (vga_rdata !== e) $display("FAIL stream_rdata got %h exp %h", vga_rdata, e);
                    else n_pass++;
                end
            end
            if (c < 8) begin
                n_checks++;
                if (vga_ack !== 1'b1 || mem_addr !== 24'(nxt))
                    $display("FAIL stream_ack cycle %0d got ack=%b addr=%h exp ack=1 addr=%h", c, vga_ack, mem_addr, 24'(nxt));
                else n_pass++;
            end
            prev_ack = vga_ack;
            if (vga_ack) begin
                nack++;
                nxt++;
                if (nxt < 8) begin
                    vga_addr = 24'(nxt);
                    exp_vga.push_back(16'h0100 + 16'(nxt));
                end else begin
                    vga_req = 1'b0;
                end
            end
        end
        n_checks++;
        if (nack != 8 || nrv != 8) $display("FAIL stream_counts got ack=%0d rvalid=%0d exp 8/8", nack, nrv);
        else n_pass++;
    endtask

    task automatic test_core_wr_rd;
        int phase = 0;
        int nwe = 0;
        int vrv = 0;
        logic prev_rd_ack = 1'b0;
        logic [15:0] e;
        core_req = 1'b1; core_we = 1'b1; core_addr = 24'h0000A0; core_wdata = 16'hBEEF;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (mem_we) nwe++;
            if (vga_rvalid) vrv++;
            n_checks++;
            if (core_rvalid !== prev_rd_ack)
                $display("FAIL core_rvalid_latency cycle %0d got %b exp %b", c, core_rvalid, prev_rd_ack);
            else n_pass++;
            if (core_rvalid) begin
                n_checks++;
                if (exp_core.size() == 0) begin
                    $display("FAIL core_unexpected_rvalid got data %h exp none", core_rdata);
                end else begin
                    e = exp_core.pop_front();
                    if (core_rdata !== e) $display("FAIL core_raw_rdata got %h exp %h", core_rdata, e);
                    else n_pass++;
                end
            end
            prev_rd_ack = 1'b0;
            if (core_ack) begin
                if (phase == 0) begin
                    n_checks++;
                    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 24'h0000A0, 16'hBEEF})
                        $display("FAIL core_write_drive got we=%b addr=%h wdata=%h exp 1/0000a0/beef", mem_we, mem_addr, mem_wdata);
                    else n_pass++;
                    phase = 1;
                    core_we = 1'b0;
                    exp_core.push_back(16'hBEEF);
                end else if (phase == 1) begin
                    n_checks++;
                    if ({mem_we, mem_addr} !== {1'b0, 24'h0000A0})
                        $display("FAIL core_read_drive got we=%b addr=%h exp 0/0000a0", mem_we, mem_addr);
                    else n_pass++;
                    phase = 2;
                    core_req = 1'b0;
                    prev_rd_ack = 1'b1;
                end
            end
        end
        n_checks++;
        if (phase != 2 || nwe != 1 || vrv != 0)
            $display("FAIL core_wr_rd_summary got phase=%0d we_cycles=%0d vga_rvalid=%0d exp 2/1/0", phase, nwe, vrv);
        else n_pass++;
    endtask

    task automatic test_simultaneous;
        logic [15:0] e;
        vga_req = 1'b1; vga_addr = 24'h000030;
        core_req = 1'b1; core_we = 1'b0; core_addr = 24'h000040;
        exp_vga.push_back(16'h0130);
        exp_core.push_back(16'h0140);
        tick();
        n_checks++;
        if ({vga_ack, core_ack} !== 2'b10) $display("FAIL simul_first_grant got %b exp 10", {vga_ack, core_ack});
        else n_pass++;
        vga_req = 1'b0;
        tick();
        n_checks++;
        if ({vga_ack, core_ack} !== 2'b01) $display("FAIL simul_second_grant got %b exp 01", {vga_ack, core_ack});
        else n_pass++;
        core_req = 1'b0;
        e = exp_vga.pop_front();
        n_checks++;
        if (vga_rvalid !== 1'b1 || vga_rdata !== e)
            $display("FAIL simul_vga_return got v=%b d=%h exp 1/%h", vga_rvalid, vga_rdata, e);
        else n_pass++;
        tick();
        e = exp_core.pop_front();
        n_checks++;
        if (core_rvalid !== 1'b1 || core_rdata !== e || vga_rvalid !== 1'b0)
            $display("FAIL simul_core_return got cv=%b cd=%h vv=%b exp 1/%h/0", core_rvalid, core_rdata, vga_rvalid, e);
        else n_pass++;
        tick();
        n_checks++;
        if ({vga_rvalid, core_rvalid, vga_rdata, core_rdata} !== {2'b00, 16'h0130, 16'h0140})
            $display("FAIL simul_rdata_hold got %b %h %h exp 00 0130 0140", {vga_rvalid, core_rvalid}, vga_rdata, core_rdata);
        else n_pass++;
    endtask

    task automatic test_starvation;
        int order[$];
        int nv_issued = 1;
        int lead = 0;
        logic pv = 1'b0;
        logic pc = 1'b0;
        logic [15:0] e;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vga_req = 1'b1; vga_addr = 24'h000050;
        exp_vga.push_back(16'h0150);
        core_req = 1'b1; core_we = 1'b0; core_addr = 24'h000060;
        exp_core.push_back(16'h0160);
        for (int c = 0; c < 16; c++) begin
            tick();
            n_checks++;
            if ((vga_ack && core_ack) || vga_rvalid !== pv || core_rvalid !== pc)
                $display("FAIL starve_cycle %0d got acks=%b%b rv=%b%b exp single ack, rv=%b%b",
                         c, vga_ack, core_ack, vga_rvalid, core_rvalid, pv, pc);
            else n_pass++;
            if (vga_rvalid && exp_vga.size() != 0) begin
                e = exp_vga.pop_front();
                n_checks++;
                if (vga_rdata !== e) $display("FAIL starve_vga_rdata got %h exp %h", vga_rdata, e);
                else n_pass++;
            end
            if (core_rvalid && exp_core.size() != 0) begin
                e = exp_core.pop_front();
                n_checks++;
                if (core_rdata !== e) $display("FAIL starve_core_rdata got %h exp %h", core_rdata, e);
                else n_pass++;
            end
            pv = vga_ack;
            pc = core_ack;
            if (vga_ack) begin
                order.push_back(1);
                if (nv_issued < 8) begin
                    vga_addr = vga_addr + 24'd1;
                    exp_vga.push_back(16'h0150 + 16'(nv_issued));
                    nv_issued++;
                end else begin
                    vga_req = 1'b0;
                end
            end
            if (core_ack) begin
                order.push_back(2);
                core_req = 1'b0;
            end
        end
        foreach (order[i]) begin
            if (order[i] != 1) break;
            lead++;
        end
        n_checks++;
        if (lead != 4) $display("FAIL starve_vga_before_core got %0d exp 4", lead);
        else n_pass++;
        n_checks++;
        if (order.size() != 9 || order[4] != 2 || order[5] != 1)
            $display("FAIL starve_order got %0d grants exp 9 with core 5th then vga", order.size());
        else n_pass++;
        n_checks++;
        if (exp_vga.size() != 0 || exp_core.size() != 0)
            $display("FAIL starve_pending_returns got vga=%0d core=%0d exp 0/0", exp_vga.size(), exp_core.size());
        else n_pass++;
`ifdef VRAM_ARB_STATS_EN
        n_checks++;
        if (stat_core_stall !== 16'd4) $display("FAIL stat_core_stall got %0d exp 4", stat_core_stall);
        else n_pass++;
        n_checks++;
        if (stat_forced !== 16'd1) $display("FAIL stat_forced got %0d exp 1", stat_forced);
        else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_vga_stream();
        test_core_wr_rd();
        test_simultaneous();
        test_starvation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
